// File: rtl/mem_port_arbiter_if.sv
// Request/grant/response bundle between fetch, data and ram sides of mem_port_arbiter.
// Debug requester signals exist only when MEM_ARB_DBG_EN is defined.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
);
`ifdef MEM_ARB_DBG_EN
    logic              dbg_req;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic [1:0]        dbg_size;
    logic              dbg_gnt;
    logic              dbg_rvalid;
    logic [DATA_W-1:0] dbg_rdata;
`endif
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              d_req;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [1:0]        d_size;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [1:0]        m_size;
    logic [DATA_W-1:0] m_rdata;

    // Requesters and the ram together form the master side.
    modport master (
`ifdef MEM_ARB_DBG_EN
        output dbg_req, output dbg_addr, output dbg_wdata, output dbg_size,
        input  dbg_gnt, input  dbg_rvalid, input  dbg_rdata,
`endif
        output if_req, output if_addr,
        input  if_gnt, input  if_rvalid, input  if_rdata,
        output d_req, output d_addr, output d_wdata, output d_size,
        input  d_gnt, input  d_rvalid, input  d_rdata,
        input  m_addr, input  m_wdata, input  m_size,
        output m_rdata
    );

    modport slave (
`ifdef MEM_ARB_DBG_EN
        input  dbg_req, input  dbg_addr, input  dbg_wdata, input  dbg_size,
        output dbg_gnt, output dbg_rvalid, output dbg_rdata,
`endif
        input  if_req, input  if_addr,
        output if_gnt, output if_rvalid, output if_rdata,
        input  d_req, input  d_addr, input  d_wdata, input  d_size,
        output d_gnt, output d_rvalid, output d_rdata,
        output m_addr, output m_wdata, output m_size,
        input  m_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port ram arbiter for fetch and data requesters with a 2-stage response tag pipe.
// Define MEM_ARB_DBG_EN to add a debug requester with absolute priority.
module mem_port_arbiter #(
    parameter int ADDR_W     = 14,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              resetn,
    mem_port_arbiter_if.slave bus
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

`ifdef MEM_ARB_DBG_EN
    typedef enum logic [1:0] {
        OWN_FETCH = 2'd0,
        OWN_DATA  = 2'd1,
        OWN_DBG   = 2'd2
    } owner_e;
`else
    typedef enum logic [0:0] {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } owner_e;
`endif

    typedef struct packed {
        logic   valid;
        owner_e owner;
        logic   is_load;
    } tag_t;

    logic              if_gnt;
    logic              d_gnt;
    logic              dbg_gnt;
    logic              fetch_wins;

    logic [3:0]        starve_cnt_q, starve_cnt_d;
    logic [ADDR_W-1:0] m_addr_q,     m_addr_d;
    logic [DATA_W-1:0] m_wdata_q,    m_wdata_d;
    logic [1:0]        m_size_q,     m_size_d;
    tag_t              tag0_q,       tag0_d;
    tag_t              tag1_q,       tag1_d;

    // Data normally wins; fetch wins only once data has starved it STARVE_MAX times.
    always_comb begin
        dbg_gnt = 1'b0;
`ifdef MEM_ARB_DBG_EN
        dbg_gnt = resetn && bus.dbg_req;
`endif
        fetch_wins = bus.if_req && (!bus.d_req || (starve_cnt_q == STARVE_LIM));
        if_gnt     = resetn && !dbg_gnt && fetch_wins;
        d_gnt      = resetn && !dbg_gnt && bus.d_req && !fetch_wins;
    end

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!resetn) begin
            starve_cnt_d = '0;
        end else if (dbg_gnt) begin
            starve_cnt_d = starve_cnt_q;
        end else if (!bus.if_req || if_gnt) begin
            starve_cnt_d = '0;
        end else if (d_gnt && (starve_cnt_q != STARVE_LIM)) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end

    // Register the granted request onto the ram port and tag its response slot.
    always_comb begin
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        m_size_d  = 2'b00;
        tag0_d    = '0;
        if (!resetn) begin
            m_addr_d  = '0;
            m_wdata_d = '0;
`ifdef MEM_ARB_DBG_EN
        end else if (dbg_gnt) begin
            m_addr_d       = bus.dbg_addr;
            m_wdata_d      = bus.dbg_wdata;
            m_size_d       = bus.dbg_size;
            tag0_d.valid   = 1'b1;
            tag0_d.owner   = OWN_DBG;
            tag0_d.is_load = (bus.dbg_size == 2'b00);
`endif
        end else if (d_gnt) begin
            m_addr_d       = bus.d_addr;
            m_wdata_d      = bus.d_wdata;
            m_size_d       = bus.d_size;
            tag0_d.valid   = 1'b1;
            tag0_d.owner   = OWN_DATA;
            tag0_d.is_load = (bus.d_size == 2'b00);
        end else if (if_gnt) begin
            m_addr_d       = bus.if_addr;
            tag0_d.valid   = 1'b1;
            tag0_d.owner   = OWN_FETCH;
            tag0_d.is_load = 1'b1;
        end
        tag1_d = resetn ? tag0_q : '0;
    end

    always_ff @(posedge clk) begin
        starve_cnt_q <= starve_cnt_d;
        m_addr_q     <= m_addr_d;
        m_wdata_q    <= m_wdata_d;
        m_size_q     <= m_size_d;
        tag0_q       <= tag0_d;
        tag1_q       <= tag1_d;
    end

    assign bus.if_gnt    = if_gnt;
    assign bus.d_gnt     = d_gnt;
    assign bus.if_rvalid = tag1_q.valid && (tag1_q.owner == OWN_FETCH);
    assign bus.d_rvalid  = tag1_q.valid && (tag1_q.owner == OWN_DATA) && tag1_q.is_load;
    assign bus.if_rdata  = bus.m_rdata;
    assign bus.d_rdata   = bus.m_rdata;
`ifdef MEM_ARB_DBG_EN
    assign bus.dbg_gnt    = dbg_gnt;
    assign bus.dbg_rvalid = tag1_q.valid && (tag1_q.owner == OWN_DBG) && tag1_q.is_load;
    assign bus.dbg_rdata  = bus.m_rdata;
`endif
    assign bus.m_addr    = m_addr_q;
    assign bus.m_wdata   = m_wdata_q;
    assign bus.m_size    = m_size_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a registered-read ram model.
// Debug-requester steps compile only when MEM_ARB_DBG_EN is defined.
module tb_mem_port_arbiter;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    int   testCount = 0;
    int   failCount = 0;

    logic [31:0] mem [0:4095];

    mem_port_arbiter_if #(.ADDR_W(14), .DATA_W(32)) bus ();

    mem_port_arbiter #(.ADDR_W(14), .DATA_W(32), .STARVE_MAX(4)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Byte-lane write merge as the ram applies it, offset by the low address bits.
    function automatic logic [31:0] mergeWord(input logic [31:0] oldWord, input logic [31:0] wdata,
                                              input logic [1:0] size, input logic [1:0] off);
        logic [31:0] r;
        int o;
        r = oldWord;
        o = int'(off);
        for (int b = 0; b < 4; b++) begin
            if (size == 2'b11) r[8*b +: 8] = wdata[8*b +: 8];
            else if (size == 2'b01 && b == o) r[8*b +: 8] = wdata[7:0];
            else if (size == 2'b10 && b == o) r[8*b +: 8] = wdata[7:0];
            else if (size == 2'b10 && b == o + 1) r[8*b +: 8] = wdata[15:8];
        end
        return r;
    endfunction

    // Ram model: reads one cycle after the address is presented, writes when m_size != 0.
    always @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 32'hC0DE_0000 | 32'(i);
            bus.m_rdata <= '0;
        end else begin
            bus.m_rdata <= mem[bus.m_addr[13:2]] >> {bus.m_addr[1:0], 3'b000};
            if (bus.m_size != 2'b00)
                mem[bus.m_addr[13:2]] <= mergeWord(mem[bus.m_addr[13:2]], bus.m_wdata,
                                                   bus.m_size, bus.m_addr[1:0]);
        end
    end

    task automatic applyStimulus(input logic ifReq, input logic [13:0] ifAddr, input logic dReq,
                                 input logic [13:0] dAddr, input logic [31:0] dWdata,
                                 input logic [1:0] dSize);
        bus.if_req  = ifReq;
        bus.if_addr = ifAddr;
        bus.d_req   = dReq;
        bus.d_addr  = dAddr;
        bus.d_wdata = dWdata;
        bus.d_size  = dSize;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic toCheckPoint;
        @(negedge clk);
    endtask

    task automatic nextCycle;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [9:0] order;
        logic [4:0] order5;

`ifdef MEM_ARB_DBG_EN
        bus.dbg_req   = 1'b0;
        bus.dbg_addr  = '0;
        bus.dbg_wdata = '0;
        bus.dbg_size  = 2'b00;
`endif
        // Reset with both requests asserted: no grants may leak out.
        applyStimulus(1'b1, 14'h0, 1'b1, 14'h100, 32'h0, 2'b00);
        resetn = 1'b0;
        nextCycle;
        toCheckPoint;
        checkOutput("reset if_gnt", bus.if_gnt, 1'b0);
        checkOutput("reset d_gnt", bus.d_gnt, 1'b0);
        nextCycle;
        resetn = 1'b1;
        applyStimulus(1'b0, 14'h0, 1'b0, 14'h0, 32'h0, 2'b00);
        toCheckPoint;
        checkOutput("reset m_addr", 32'(bus.m_addr), 32'h0);
        checkOutput("reset m_size", 32'(bus.m_size), 32'h0);
        checkOutput("reset m_wdata", bus.m_wdata, 32'h0);
        checkOutput("reset if_rvalid", bus.if_rvalid, 1'b0);
        checkOutput("reset d_rvalid", bus.d_rvalid, 1'b0);
        checkOutput("idle if_gnt", bus.if_gnt, 1'b0);
        nextCycle;

        // Back-to-back fetches of words 0..2.
        applyStimulus(1'b1, 14'h0000, 1'b0, 14'h0, 32'h0, 2'b00);
        toCheckPoint;
        checkOutput("fetch0 if_gnt", bus.if_gnt, 1'b1);
        checkOutput("fetch0 d_gnt", bus.d_gnt, 1'b0);
        nextCycle;
        applyStimulus(1'b1, 14'h0004, 1'b0, 14'h0, 32'h0, 2'b00);
        toCheckPoint;
        checkOutput("fetch1 if_gnt", bus.if_gnt, 1'b1);
        checkOutput("fetch1 m_addr", 32'(bus.m_addr), 32'h0);
        checkOutput("fetch1 if_rvalid", bus.if_rvalid, 1'b0);
        nextCycle;
        applyStimulus(1'b1, 14'h0008, 1'b0, 14'h0, 32'h0, 2'b00);
        toCheckPoint;
        checkOutput("fetch2 if_gnt", bus.if_gnt, 1'b1);
        checkOutput("fetch2 m_addr", 32'(bus.m_addr), 32'h4);
        checkOutput("fetch rsp0 valid", bus.if_rvalid, 1'b1);
        checkOutput("fetch rsp0 data", bus.if_rdata, 32'hC0DE_0000);
        nextCycle;
        applyStimulus(1'b0, 14'h0, 1'b0, 14'h0, 32'h0, 2'b00);
        toCheckPoint;
        checkOutput("fetch rsp1 valid", bus.if_rvalid, 1'b1);
        checkOutput("fetch rsp1 data", bus.if_rdata, 32'hC0DE_0001);
        checkOutput("fetch rsp1 d_rvalid", bus.d_rvalid, 1'b0);
        nextCycle;
        toCheckPoint;
        checkOutput("fetch rsp2 valid", bus.if_rvalid, 1'b1);
        checkOutput("fetch rsp2 data", bus.if_rdata, 32'hC0DE_0002);
        nextCycle;
        toCheckPoint;
        checkOutput("fetch drained", bus.if_rvalid, 1'b0);
        nextCycle;

        // Store32 followed by a load of the same word.
        applyStimulus(1'b0, 14'h0, 1'b1, 14'h0100, 32'hDEAD_BEEF, 2'b11);
        toCheckPoint;
        checkOutput("store d_gnt", bus.d_gnt, 1'b1);
        checkOutput("store if_gnt", bus.if_gnt, 1'b0);
        nextCycle;
        applyStimulus(1'b0, 14'h0, 1'b1, 14'h0100, 32'h0, 2'b00);
        toCheckPoint;
        checkOutput("load d_gnt", bus.d_gnt, 1'b1);
        checkOutput("store m_size", 32'(bus.m_size), 32'h3);
        checkOutput("store m_addr", 32'(bus.m_addr), 32'h100);
        checkOutput("store m_wdata", bus.m_wdata, 32'hDEAD_BEEF);
        nextCycle;
        applyStimulus(1'b0, 14'h0, 1'b0, 14'h0, 32'h0, 2'b00);
        toCheckPoint;
        checkOutput("load m_size", 32'(bus.m_size), 32'h0);
        checkOutput("store no rvalid", bus.d_rvalid, 1'b0);
        nextCycle;
        toCheckPoint;
        checkOutput("load rvalid", bus.d_rvalid, 1'b1);
        checkOutput("load rdata", bus.d_rdata, 32'hDEAD_BEEF);
        checkOutput("load if_rvalid", bus.if_rvalid, 1'b0);
        nextCycle;
        toCheckPoint;
        checkOutput("load single pulse", bus.d_rvalid, 1'b0);
        nextCycle;

        // Starvation limit: D,D,D,D,F repeating with both requests held.
        order = 10'b10_0001_0000;
        applyStimulus(1'b1, 14'h0040, 1'b1, 14'h0100, 32'h0, 2'b00);
        for (int i = 0; i < 10; i++) begin
            toCheckPoint;
            checkOutput("starve if_gnt", bus.if_gnt, order[i]);
            checkOutput("starve d_gnt", bus.d_gnt, !order[i]);
            nextCycle;
        end
        for (int i = 0; i < 3; i++) begin
            toCheckPoint;
            checkOutput("pre-drop d_gnt", bus.d_gnt, 1'b1);
            nextCycle;
        end
        // Dropping if_req clears the count, so four more data grants follow.
        applyStimulus(1'b0, 14'h0040, 1'b1, 14'h0100, 32'h0, 2'b00);
        toCheckPoint;
        checkOutput("drop d_gnt", bus.d_gnt, 1'b1);
        nextCycle;
        order5 = 5'b10000;
        applyStimulus(1'b1, 14'h0040, 1'b1, 14'h0100, 32'h0, 2'b00);
        for (int i = 0; i < 5; i++) begin
            toCheckPoint;
            checkOutput("post-drop if_gnt", bus.if_gnt, order5[i]);
            nextCycle;
        end
        applyStimulus(1'b0, 14'h0, 1'b0, 14'h0, 32'h0, 2'b00);
        nextCycle;
        nextCycle;
        nextCycle;

        // Reset while a load is in flight, with starve count at 3.
        applyStimulus(1'b1, 14'h0040, 1'b1, 14'h0100, 32'h0, 2'b00);
        for (int i = 0; i < 3; i++) begin
            toCheckPoint;
            checkOutput("prereset d_gnt", bus.d_gnt, 1'b1);
            nextCycle;
        end
        resetn = 1'b0;
        toCheckPoint;
        checkOutput("midreset d_gnt", bus.d_gnt, 1'b0);
        checkOutput("midreset if_gnt", bus.if_gnt, 1'b0);
        checkOutput("midreset old rvalid", bus.d_rvalid, 1'b1);
        nextCycle;
        resetn = 1'b1;
        toCheckPoint;
        checkOutput("postreset d_rvalid", bus.d_rvalid, 1'b0);
        checkOutput("postreset m_size", 32'(bus.m_size), 32'h0);
        checkOutput("postreset m_addr", 32'(bus.m_addr), 32'h0);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) toCheckPoint;
            checkOutput("postreset if_gnt", bus.if_gnt, order5[i]);
            if (i == 1) checkOutput("postreset no stale rvalid", bus.d_rvalid, 1'b0);
            nextCycle;
        end
        applyStimulus(1'b0, 14'h0, 1'b0, 14'h0, 32'h0, 2'b00);
        nextCycle;
        nextCycle;
        nextCycle;

        // Partial stores merge into the word; loads see the prior-cycle store.
        applyStimulus(1'b0, 14'h0, 1'b1, 14'h0200, 32'h1122_3344, 2'b11);
        toCheckPoint;
        checkOutput("merge store32 d_gnt", bus.d_gnt, 1'b1);
        nextCycle;
        applyStimulus(1'b0, 14'h0, 1'b1, 14'h0202, 32'h0000_ABCD, 2'b10);
        nextCycle;
        applyStimulus(1'b0, 14'h0, 1'b1, 14'h0200, 32'h0, 2'b00);
        nextCycle;
        applyStimulus(1'b0, 14'h0, 1'b1, 14'h0203, 32'h0000_00EE, 2'b01);
        toCheckPoint;
        checkOutput("store16 no rvalid", bus.d_rvalid, 1'b0);
        nextCycle;
        applyStimulus(1'b0, 14'h0, 1'b1, 14'h0200, 32'h0, 2'b00);
        toCheckPoint;
        checkOutput("store16 load rvalid", bus.d_rvalid, 1'b1);
        checkOutput("store16 load rdata", bus.d_rdata, 32'hABCD_3344);
        nextCycle;
        applyStimulus(1'b0, 14'h0, 1'b0, 14'h0, 32'h0, 2'b00);
        toCheckPoint;
        checkOutput("store8 no rvalid", bus.d_rvalid, 1'b0);
        nextCycle;
        toCheckPoint;
        checkOutput("store8 load rvalid", bus.d_rvalid, 1'b1);
        checkOutput("store8 load rdata", bus.d_rdata, 32'hEECD_3344);
        nextCycle;

`ifdef MEM_ARB_DBG_EN
        // Debug wins outright and leaves the starve count untouched (2 before, 2 after).
        applyStimulus(1'b1, 14'h0040, 1'b1, 14'h0100, 32'h0, 2'b00);
        nextCycle;
        nextCycle;
        bus.dbg_req = 1'b1;
        bus.dbg_addr = 14'h0200;
        for (int i = 0; i < 2; i++) begin
            toCheckPoint;
            checkOutput("dbg dbg_gnt", bus.dbg_gnt, 1'b1);
            checkOutput("dbg d_gnt", bus.d_gnt, 1'b0);
            checkOutput("dbg if_gnt", bus.if_gnt, 1'b0);
            nextCycle;
        end
        bus.dbg_req = 1'b0;
        toCheckPoint;
        checkOutput("dbg rvalid", bus.dbg_rvalid, 1'b1);
        checkOutput("dbg rdata", bus.dbg_rdata, 32'hEECD_3344);
        checkOutput("after dbg d_gnt 1", bus.d_gnt, 1'b1);
        nextCycle;
        toCheckPoint;
        checkOutput("after dbg d_gnt 2", bus.d_gnt, 1'b1);
        nextCycle;
        toCheckPoint;
        checkOutput("after dbg if_gnt", bus.if_gnt, 1'b1);
        nextCycle;
        applyStimulus(1'b0, 14'h0, 1'b0, 14'h0, 32'h0, 2'b00);
        nextCycle;
`endif

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
